unit_div: RTL and testbench

Sequential 32-bit restoring divider for the datapath, the inverse companion to the adder/subtractor unit: where that unit composes a result from operands in one combinational pass, this block decomposes a dividend by repeated trial subtraction, one quotient bit per clock. It sits beside the arithmetic unit in the execute stage and uses a start/done handshake. It produces quotient, remainder and status flags.

---
 rtl/unit_div.sv | 137 +++++++++++++
 tb/tb_unit_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/unit_div.sv
// Sequential 32-bit restoring divider: one quotient bit per clock, start/done handshake.
// Optional signed support is enabled by defining UNIT_DIV_SIGNED_EN.
module unit_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dz,
  output logic        O
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] div;
  logic        dz_p;
  logic [32:0] diff;
  logic [31:0] ld_a;
  logic [31:0] ld_b;

`ifdef UNIT_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic ovf_p;
  logic O_q;

  assign O = O_q;

  // Core always divides magnitudes; signs are reapplied on the FIN edge.
  always_comb begin
    ld_a = (sgn && a[31]) ? (~a + 32'd1) : a;
    ld_b = (sgn && b[31]) ? (~b + 32'd1) : b;
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign O          = 1'b0;

  always_comb begin
    ld_a = a;
    ld_b = b;
  end
`endif

  always_comb begin
    diff = {rem, dvd[31]} - {1'b0, div};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      div   <= '0;
      dz_p  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
`ifdef UNIT_DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf_p <= 1'b0;
      O_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= 5'd31;
            div  <= ld_b;
            if (b == '0) begin
              // Divide by zero bypasses RUN; rem/dvd carry the fixed result.
              rem   <= a;
              dvd   <= '1;
              dz_p  <= 1'b1;
              state <= FIN;
            end else begin
              rem   <= '0;
              dvd   <= ld_a;
              dz_p  <= 1'b0;
              state <= RUN;
            end
`ifdef UNIT_DIV_SIGNED_EN
            neg_q <= sgn && (b != '0) && (a[31] ^ b[31]);
            neg_r <= sgn && (b != '0) && a[31];
            ovf_p <= sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`endif
          end
        end
        RUN: begin
          if (diff[32]) begin
            rem <= {rem[30:0], dvd[31]};
          end else begin
            rem <= diff[31:0];
          end
          dvd <= {dvd[30:0], ~diff[32]};
          if (cnt == '0) begin
            state <= FIN;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          dz    <= dz_p;
`ifdef UNIT_DIV_SIGNED_EN
          q     <= neg_q ? (~dvd + 32'd1) : dvd;
          r     <= neg_r ? (~rem + 32'd1) : rem;
          O_q   <= ovf_p;
`else
          q     <= dvd;
          r     <= rem;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_div.sv
// Scoreboard bench for unit_div: driver pushes expected results, monitor checks on done.
module tb_unit_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dz;
  logic        O;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  unit_div dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sgn  (sgn),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dz   (dz),
    .O    (O)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    exp_t e;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    e.lat = 33;
    if (tb == 0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = ta;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.q = ta / tb;
      e.r = ta % tb;
`ifdef UNIT_DIV_SIGNED_EN
      if (ts) begin
        if (ta == 32'h8000_0000 && tb == 32'hFFFF_FFFF) begin
          e.q   = 32'h8000_0000;
          e.r   = 32'h0;
          e.ovf = 1'b1;
        end else begin
          e.q = $signed(ta) / $signed(tb);
          e.r = $signed(ta) % $signed(tb);
        end
      end
`else
      if (ts) e.lat = 33;
`endif
    end
    return e;
  endfunction

  // Called just after a falling edge while the divider is idle.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    exp_t e;
    e     = model(ta, tb, ts);
    e.acc = cyc;
    sb.push_back(e);
    a     = ta;
    b     = tb;
    sgn   = ts;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("dz", {31'b0, dz}, {31'b0, e.dz});
        chk("ovf", {31'b0, O}, {31'b0, e.ovf});
        chk("latency", cyc - e.acc - 1, e.lat);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_flags", {30'b0, dz, O}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    issue(32'd100, 32'd7, 1'b0);                 drain();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);           drain();
    issue(32'd5, 32'd0, 1'b0);                   drain();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);           drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   drain();
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);           drain();
    issue(32'd5, 32'd0, 1'b1);                   drain();

    // Start pulsed while busy must not disturb the running division.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    drain();

    // Reset mid-RUN aborts the operation and clears outputs at once.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    chk("midrst_flags", {30'b0, dz, O}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_idle", {30'b0, busy, done}, 32'd0);
    issue(32'd9, 32'd9, 1'b0);                   drain();

    // Back-to-back: the next issue lands right after done is observed.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 16);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      issue(ra, rb, 1'(($urandom_range(0, 1))));
      drain();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
